dot_product_seq: RTL and testbench
==================================

Name: dot_product_seq

Overview:
- Sequencer that computes an unsigned dot product of two operand vectors held in synchronous operand memories (A bank, B bank).
- Issues element addresses and drives the shared A*B multiplier, accumulating one product per cycle.
- Returns the sum over a valid/ready handshake.
- Sits between the control unit, which issues start/len, and the operand memories and multiplier of the inference datapath.

Parameters:
- DATA_WIDTH, 8, operand element width (unsigned).
- ADDR_WIDTH, 4, operand memory address width; max vector length 2**ADDR_WIDTH.
- ACC_WIDTH, 2*DATA_WIDTH+ADDR_WIDTH, accumulator/result width; sized so overflow is impossible.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request new dot product; sampled only in IDLE.
- len  input  ADDR_WIDTH+1  element count, 0..2**ADDR_WIDTH, sampled with start.
- busy  output  1  high whenever state != IDLE.
- rd_en  output  1  read strobe to both operand memories.
- addr  output  ADDR_WIDTH  element index to both memories.
- a_data  input  DATA_WIDTH  A element, valid exactly 1 cycle after rd_en.
- b_data  input  DATA_WIDTH  B element, valid exactly 1 cycle after rd_en.
- result  output  ACC_WIDTH  accumulated sum.
- result_valid  output  1  result available.
- result_ready  input  1  consumer accepts result.

Behaviour:
- Decided: one clock; reset is asynchronous and active-low (clk, rst_n).
- rst_n low, at any time including mid-operation: state=IDLE, busy=0, rd_en=0, addr=0, result=0, result_valid=0, accumulator=0, internal data-pending flag=0. No partial result survives reset.
- All outputs are registered; busy is decoded from the state register.
- Arithmetic is unsigned. Each product is DATA_WIDTH*2 bits, zero-extended to ACC_WIDTH before the add. No wrap is possible for len <= 2**ADDR_WIDTH.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1, len>0: latch len, clear accumulator, go to RUN with addr=0, rd_en=1.
  - start=1, len=0: go to DONE with result=0.
  - start=0: remain in IDLE.
- RUN:
  - rd_en=1 every cycle; addr increments by 1 per cycle.
  - When addr==len-1 (last issue), next state is DRAIN, rd_en=0, and addr holds its last value.
- Data-pending flag: rd_en delayed by one cycle. In any cycle where the flag is 1, acc <= acc + a_data*b_data at the clock edge.
- DRAIN: one cycle; the last product is accumulated; next state DONE; result <= final accumulator value.
- DONE:
  - result_valid=1, result held stable.
  - On result_valid && result_ready: result_valid <= 0, state <= IDLE. result keeps its value until the next start clears it.
- Latency: start sampled at edge E0 with len=N>0.
  - rd_en high during cycles 1..N.
  - result_valid rises in cycle N+2.
  - len=0: result_valid in cycle 1.
- Throughput: no new start is accepted until the handshake completes plus one IDLE cycle.
- start while busy: ignored, no effect on len or accumulator.
- len input changes while busy: ignored.
- result_ready high before DONE: no effect.
- Full length len=2**ADDR_WIDTH: addr runs 0..2**ADDR_WIDTH-1 with no wrap to 0 while reading.

Test Plan:
1. len=3, A={1,2,3}, B={4,5,6} -> rd_en high cycles 1-3, addr 0,1,2; result=32, result_valid in cycle 5; ready=1 -> IDLE next cycle, busy=0.
2. len=0, start -> result_valid in cycle 1 with result=0; rd_en never asserted.
3. len=16, all A=B=255 -> result=1040400 (16*65025), no overflow; addr sequence 0..15 then hold 15.
4. Hold result_ready=0 for 10 cycles in DONE while pulsing start with len=2 -> result_valid and result unchanged and start ignored; ready=1 -> single handshake, then IDLE.
5. Assert rst_n=0 mid-RUN (cycle 2 of len=8) -> all outputs 0 immediately (asynchronously); after release, start len=1 A={7} B={9} -> result=63 with no residue from the aborted run.
6. Back-to-back: run len=2 {1,1}·{1,1} (=2), handshake, then start len=2 {3,0}·{5,9} -> second result=15, confirming the accumulator is cleared.

Source files
------------

// File: rtl/dot_product_seq.sv
// dot_product_seq: sequencer for an unsigned dot product over two synchronous operand memories.
// It issues one read per cycle, accumulates a_data*b_data, and returns the sum over valid/ready.
`default_nettype none

module dot_product_seq #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 4,
   parameter int ACC_WIDTH  = 2*DATA_WIDTH+ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [ADDR_WIDTH:0]   len,
   output logic                  busy,
   output logic                  rd_en,
   output logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] a_data,
   input  logic [DATA_WIDTH-1:0] b_data,
   output logic [ACC_WIDTH-1:0]  result,
   output logic                  result_valid,
   input  logic                  result_ready
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   last_addr;
   logic [ACC_WIDTH-1:0]    acc;
   logic                    pending;

   logic [2*DATA_WIDTH-1:0] product;
   logic [ACC_WIDTH-1:0]    acc_next;
   logic [ADDR_WIDTH:0]     len_m1;

   assign product  = {{DATA_WIDTH{1'b0}}, a_data} * {{DATA_WIDTH{1'b0}}, b_data};
   assign acc_next = pending ? acc + {{(ACC_WIDTH-2*DATA_WIDTH){1'b0}}, product} : acc;
   // Only the index of the last element is kept; len is nonzero whenever this is latched.
   assign len_m1   = len - (ADDR_WIDTH+1)'(1);
   assign busy     = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         last_addr    <= '0;
         acc          <= '0;
         pending      <= 1'b0;
         rd_en        <= 1'b0;
         addr         <= '0;
         result       <= '0;
         result_valid <= 1'b0;
      end else begin
         pending <= rd_en;
         acc     <= acc_next;
         case (state)
            IDLE: begin
               rd_en <= 1'b0;
               if (start) begin
                  result <= '0;
                  acc    <= '0;
                  addr   <= '0;
                  if (len != '0) begin
                     last_addr <= len_m1[ADDR_WIDTH-1:0];
                     rd_en     <= 1'b1;
                     state     <= RUN;
                  end else begin
                     result_valid <= 1'b1;
                     state        <= DONE;
                  end
               end
            end
            RUN: begin
               if (addr == last_addr) begin
                  rd_en <= 1'b0;
                  state <= DRAIN;
               end else begin
                  addr <= addr + ADDR_WIDTH'(1);
               end
            end
            DRAIN: begin
               // The final product lands in acc_next on this same edge.
               result       <= acc_next;
               result_valid <= 1'b1;
               state        <= DONE;
            end
            DONE: begin
               if (result_ready) begin
                  result_valid <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dot_product_seq.sv
// tb_dot_product_seq: table-driven directed bench for dot_product_seq with synchronous operand memory models.
`default_nettype none

module tb_dot_product_seq;

   localparam int DW = 8;
   localparam int AW = 4;
   localparam int ACCW = 2*DW+AW;

   typedef struct {
      int unsigned len;
      logic [7:0]  a [16];
      logic [7:0]  b [16];
      int unsigned exp;
      bit          ready_early;
   } vec_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            start = 1'b0;
   logic [AW:0]     len = '0;
   logic            busy;
   logic            rd_en;
   logic [AW-1:0]   addr;
   logic [DW-1:0]   a_data = '0;
   logic [DW-1:0]   b_data = '0;
   logic [ACCW-1:0] result;
   logic            result_valid;
   logic            result_ready = 1'b0;

   logic [7:0] mem_a [16];
   logic [7:0] mem_b [16];

   int checks = 0;
   int failures = 0;

   vec_t tv [7];
   vec_t hold_v;
   vec_t rst_v;

   dot_product_seq #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .start        (start),
      .len          (len),
      .busy         (busy),
      .rd_en        (rd_en),
      .addr         (addr),
      .a_data       (a_data),
      .b_data       (b_data),
      .result       (result),
      .result_valid (result_valid),
      .result_ready (result_ready)
   );

   always #5 clk = ~clk;

   // Synchronous-read operand memories: data is valid the cycle after rd_en.
   always @(posedge clk) begin
      if (rd_en) begin
         a_data <= mem_a[addr];
         b_data <= mem_b[addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input int unsigned n, input int unsigned e, input bit early);
      vec_t v;
      v.len = n;
      v.exp = e;
      v.ready_early = early;
      for (int i = 0; i < 16; i++) begin
         v.a[i] = 8'd0;
         v.b[i] = 8'd0;
      end
      return v;
   endfunction

   // Starts a vector and checks every cycle up to DONE; optionally completes the handshake.
   task automatic run(input string tag, input vec_t v, input bit handshake);
      int n;
      n = int'(v.len);
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = v.a[i];
         mem_b[i] = v.b[i];
      end
      start = 1'b1;
      len = (AW+1)'(v.len);
      result_ready = v.ready_early;
      for (int k = 1; k <= n + 2; k++) begin
         @(negedge clk);
         if (k == 1) begin
            start = 1'b0;
            len = '0;
         end
         if (n == 0 && k == 2) break;
         check($sformatf("%s rd_en c%0d", tag, k), 32'(rd_en), 32'(k <= n));
         check($sformatf("%s busy c%0d", tag, k), 32'(busy), 32'd1);
         if (k <= n)
            check($sformatf("%s addr c%0d", tag, k), 32'(addr), 32'(k - 1));
         if (n > 0 && k == n + 1)
            check($sformatf("%s addr hold c%0d", tag, k), 32'(addr), 32'(n - 1));
         check($sformatf("%s result_valid c%0d", tag, k), 32'(result_valid), 32'(k == n + 2 || (n == 0 && k == 1)));
      end
      check($sformatf("%s result", tag), 32'(result), v.exp);
      if (handshake) begin
         result_ready = 1'b1;
         @(negedge clk);
         result_ready = 1'b0;
         check($sformatf("%s valid after hs", tag), 32'(result_valid), 32'd0);
         check($sformatf("%s busy after hs", tag), 32'(busy), 32'd0);
         check($sformatf("%s result kept", tag), 32'(result), v.exp);
      end
   endtask

   initial begin
      tv[0] = mk(3, 32, 1'b0);
      tv[0].a[0] = 1; tv[0].a[1] = 2; tv[0].a[2] = 3;
      tv[0].b[0] = 4; tv[0].b[1] = 5; tv[0].b[2] = 6;
      tv[1] = mk(0, 0, 1'b0);
      tv[1].a[0] = 9; tv[1].b[0] = 9;
      tv[2] = mk(16, 1040400, 1'b0);
      for (int i = 0; i < 16; i++) begin
         tv[2].a[i] = 8'd255;
         tv[2].b[i] = 8'd255;
      end
      tv[3] = mk(2, 2, 1'b0);
      tv[3].a[0] = 1; tv[3].a[1] = 1; tv[3].b[0] = 1; tv[3].b[1] = 1;
      tv[4] = mk(2, 15, 1'b0);
      tv[4].a[0] = 3; tv[4].a[1] = 0; tv[4].b[0] = 5; tv[4].b[1] = 9;
      tv[5] = mk(1, 63, 1'b1);
      tv[5].a[0] = 7; tv[5].b[0] = 9;
      tv[6] = mk(5, 550, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tv[6].a[i] = 8'((i + 1) * 10);
         tv[6].b[i] = 8'(i + 1);
      end
      hold_v = mk(2, 23, 1'b0);
      hold_v.a[0] = 2; hold_v.a[1] = 3; hold_v.b[0] = 4; hold_v.b[1] = 5;
      rst_v = mk(8, 8, 1'b0);
      for (int i = 0; i < 8; i++) begin
         rst_v.a[i] = 8'd1;
         rst_v.b[i] = 8'd1;
      end
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = 8'd0;
         mem_b[i] = 8'd0;
      end

      // Reset state
      #12;
      check("reset busy", 32'(busy), 32'd0);
      check("reset rd_en", 32'(rd_en), 32'd0);
      check("reset addr", 32'(addr), 32'd0);
      check("reset result", 32'(result), 32'd0);
      check("reset result_valid", 32'(result_valid), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 7; i++)
         run($sformatf("v%0d", i), tv[i], 1'b1);

      // DONE with result_ready held low while start pulses with a new length
      run("hold", hold_v, 1'b0);
      for (int k = 0; k < 10; k++) begin
         start = k[0];
         len = (k[0]) ? 5'd2 : 5'd5;
         @(negedge clk);
         check($sformatf("hold valid c%0d", k), 32'(result_valid), 32'd1);
         check($sformatf("hold result c%0d", k), 32'(result), 32'd23);
         check($sformatf("hold rd_en c%0d", k), 32'(rd_en), 32'd0);
      end
      start = 1'b0;
      len = '0;
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
      check("hold valid after hs", 32'(result_valid), 32'd0);
      check("hold busy after hs", 32'(busy), 32'd0);
      @(negedge clk);
      check("hold single hs valid", 32'(result_valid), 32'd0);
      check("hold single hs busy", 32'(busy), 32'd0);
      check("hold single hs rd_en", 32'(rd_en), 32'd0);

      // Asynchronous reset in cycle 2 of a len=8 run
      for (int i = 0; i < 16; i++) begin
         mem_a[i] = rst_v.a[i];
         mem_b[i] = rst_v.b[i];
      end
      start = 1'b1;
      len = 5'd8;
      @(negedge clk);
      start = 1'b0;
      len = '0;
      @(negedge clk);
      check("pre-reset rd_en", 32'(rd_en), 32'd1);
      check("pre-reset addr", 32'(addr), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async busy", 32'(busy), 32'd0);
      check("async rd_en", 32'(rd_en), 32'd0);
      check("async addr", 32'(addr), 32'd0);
      check("async result", 32'(result), 32'd0);
      check("async result_valid", 32'(result_valid), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      run("post-reset", tv[5], 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
